// File: rtl/playlist_playback_controller_pkg.sv
// Shared types and helpers for the playlist playback controller.
// Holds the play states, repeat encodings, button bit positions and width helper.
package playback_pkg;

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_PLAYING = 2'd1,
      ST_PAUSED  = 2'd2
   } play_state_t;

   localparam logic [1:0] REPEAT_OFF     = 2'd0;
   localparam logic [1:0] REPEAT_ONE     = 2'd1;
   localparam logic [1:0] REPEAT_ALL     = 2'd2;
   localparam logic [1:0] REPEAT_ALL_ALT = 2'd3;

   localparam logic [7:0] DEFAULT_END_MARKER = 8'hFF;

   localparam int BTN_PLAY_PAUSE = 0;
   localparam int BTN_NEXT       = 1;
   localparam int BTN_PREV       = 2;
   localparam int BTN_FWD_SHORT  = 3;
   localparam int BTN_BACK_SHORT = 4;
   localparam int BTN_FWD_LONG   = 5;
   localparam int BTN_BACK_LONG  = 6;
   localparam int NUM_BTNS       = 7;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int sel_width(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/playlist_playback_controller_if.sv
// Bundle of controls, ROM bus and status between the playback core and its surroundings.
// The master modport is the controller side; slave is the board/ROM side.
interface playback_if #(
   parameter int SEL_W       = 2,
   parameter int SONG_ADDR_W = 22
);
   logic                         sample_tick;
   logic                         btn_play_pause;
   logic                         btn_next;
   logic                         btn_prev;
   logic                         btn_fwd_short;
   logic                         btn_back_short;
   logic                         btn_fwd_long;
   logic                         btn_back_long;
   logic [1:0]                   repeat_mode;
   logic [7:0]                   rom_data;
   logic [SEL_W+SONG_ADDR_W-1:0] rom_addr;
   logic [SEL_W-1:0]             song_index;
   logic                         playing;
   logic [11:0]                  elapsed_s;
   logic                         song_start;

   modport master (
      input  sample_tick, btn_play_pause, btn_next, btn_prev,
             btn_fwd_short, btn_back_short, btn_fwd_long, btn_back_long,
             repeat_mode, rom_data,
      output rom_addr, song_index, playing, elapsed_s, song_start
   );

   modport slave (
      output sample_tick, btn_play_pause, btn_next, btn_prev,
             btn_fwd_short, btn_back_short, btn_fwd_long, btn_back_long,
             repeat_mode, rom_data,
      input  rom_addr, song_index, playing, elapsed_s, song_start
   );
endinterface

// File: rtl/play_position_counter.sv
// Position within the current song: sample address, sub-second count and elapsed seconds.
// Commands are mutually exclusive by construction in the controller; load_zero dominates.
module play_position_counter
   import playback_pkg::*;
#(
   parameter int SONG_ADDR_W     = 22,
   parameter int SAMPLES_PER_SEC = 8000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   advance,
   input  logic                   load_zero,
   input  logic                   seek_fwd,
   input  logic                   seek_back,
   input  logic [11:0]            step_s,
   output logic [SONG_ADDR_W-1:0] sample_addr,
   output logic [11:0]            elapsed_s
);
   localparam int               SUB_W   = sel_width(SAMPLES_PER_SEC);
   localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SAMPLES_PER_SEC - 1);

   logic [SONG_ADDR_W-1:0] sample_addr_r;
   logic [SUB_W-1:0]       sub_cnt_r;
   logic [11:0]            elapsed_r;
   logic [SONG_ADDR_W-1:0] step_addr_s;
   logic [12:0]            fwd_sum_s;

   // Address jump for a seek wraps to the per-song address width.
   assign step_addr_s = SONG_ADDR_W'(32'(step_s) * 32'(SAMPLES_PER_SEC));
   assign fwd_sum_s   = {1'b0, elapsed_r} + {1'b0, step_s};

   // Position registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_addr_r <= '0;
         sub_cnt_r     <= '0;
         elapsed_r     <= 12'd0;
      end else if (load_zero) begin
         sample_addr_r <= '0;
         sub_cnt_r     <= '0;
         elapsed_r     <= 12'd0;
      end else if (seek_fwd) begin
         sample_addr_r <= sample_addr_r + step_addr_s;
         elapsed_r     <= fwd_sum_s[12] ? 12'hFFF : fwd_sum_s[11:0];
      end else if (seek_back) begin
         if (elapsed_r >= step_s) begin
            sample_addr_r <= sample_addr_r - step_addr_s;
            elapsed_r     <= elapsed_r - step_s;
         end else begin
            sample_addr_r <= '0;
            sub_cnt_r     <= '0;
            elapsed_r     <= 12'd0;
         end
      end else if (advance) begin
         sample_addr_r <= sample_addr_r + SONG_ADDR_W'(1);
         if (sub_cnt_r == SUB_MAX) begin
            sub_cnt_r <= '0;
            elapsed_r <= (elapsed_r == 12'hFFF) ? elapsed_r : elapsed_r + 12'd1;
         end else begin
            sub_cnt_r <= sub_cnt_r + SUB_W'(1);
         end
      end
   end

   assign sample_addr = sample_addr_r;
   assign elapsed_s   = elapsed_r;
endmodule

// File: rtl/playlist_playback_controller.sv
// Playback core: button edge detection, play-state FSM, song selection and repeat handling.
// One song/position action per cycle; play_pause is decoded alongside it.
module playlist_playback_controller
   import playback_pkg::*;
#(
   parameter int         NUM_SONGS       = 4,
   parameter int         SONG_ADDR_W     = 22,
   parameter int         SAMPLES_PER_SEC = 8000,
   parameter int         SEEK_SHORT_S    = 10,
   parameter int         SEEK_LONG_S     = 30,
   parameter int         PREV_RESTART_S  = 3,
   parameter logic [7:0] END_MARKER      = DEFAULT_END_MARKER
) (
   input logic       clk,
   input logic       reset,
   playback_if.master bus
);
   localparam int               SEL_W       = sel_width(NUM_SONGS);
   localparam logic [SEL_W-1:0] LAST_SONG   = SEL_W'(NUM_SONGS - 1);
   localparam logic [11:0]      SHORT_STEP  = 12'(SEEK_SHORT_S);
   localparam logic [11:0]      LONG_STEP   = 12'(SEEK_LONG_S);
   localparam logic [11:0]      RESTART_THR = 12'(PREV_RESTART_S);

   play_state_t            state_r, state_nx_s;
   logic [NUM_BTNS-1:0]    btn_s, btn_prev_r, edge_s;
   logic                   armed_r;
   logic [SEL_W-1:0]       song_index_r, song_nx_s;
   logic                   playing_r, song_start_r;
   logic                   load_s, stop_s, advance_s, seek_fwd_s, seek_back_s, eos_s;
   logic [11:0]            step_s, elapsed_s;
   logic [SONG_ADDR_W-1:0] sample_addr_s;

   function automatic logic [SEL_W-1:0] song_inc(input logic [SEL_W-1:0] s);
      return (s == LAST_SONG) ? '0 : s + SEL_W'(1);
   endfunction

   function automatic logic [SEL_W-1:0] song_dec(input logic [SEL_W-1:0] s);
      return (s == '0) ? LAST_SONG : s - SEL_W'(1);
   endfunction

   assign btn_s = {bus.btn_back_long, bus.btn_fwd_long, bus.btn_back_short, bus.btn_fwd_short,
                   bus.btn_prev, bus.btn_next, bus.btn_play_pause};
   // The first cycle out of reset only samples levels, so a held button is not a press.
   assign edge_s = armed_r ? (btn_s & ~btn_prev_r) : '0;
   assign eos_s  = (state_r == ST_PLAYING) && bus.sample_tick && (bus.rom_data == END_MARKER);

   // Button history for rising-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_prev_r <= '0;
         armed_r    <= 1'b0;
      end else begin
         btn_prev_r <= btn_s;
         armed_r    <= 1'b1;
      end
   end

   // Prioritised song/position action selection.
   always_comb begin
      song_nx_s   = song_index_r;
      load_s      = 1'b0;
      stop_s      = 1'b0;
      advance_s   = 1'b0;
      seek_fwd_s  = 1'b0;
      seek_back_s = 1'b0;
      step_s      = 12'd0;
      if (edge_s[BTN_NEXT]) begin
         song_nx_s = song_inc(song_index_r);
         load_s    = 1'b1;
      end else if (edge_s[BTN_PREV]) begin
         song_nx_s = (elapsed_s >= RESTART_THR) ? song_index_r : song_dec(song_index_r);
         load_s    = 1'b1;
      end else if (eos_s) begin
         load_s = 1'b1;
         case (bus.repeat_mode)
            REPEAT_ONE: song_nx_s = song_index_r;
            REPEAT_OFF: begin
               song_nx_s = song_inc(song_index_r);
               stop_s    = (song_index_r == LAST_SONG);
            end
            default:    song_nx_s = song_inc(song_index_r);
         endcase
      end else if (edge_s[BTN_FWD_LONG]) begin
         seek_fwd_s = 1'b1;
         step_s     = LONG_STEP;
      end else if (edge_s[BTN_BACK_LONG]) begin
         seek_back_s = 1'b1;
         step_s      = LONG_STEP;
      end else if (edge_s[BTN_FWD_SHORT]) begin
         seek_fwd_s = 1'b1;
         step_s     = SHORT_STEP;
      end else if (edge_s[BTN_BACK_SHORT]) begin
         seek_back_s = 1'b1;
         step_s      = SHORT_STEP;
      end else if ((state_r == ST_PLAYING) && bus.sample_tick) begin
         advance_s = 1'b1;
      end else begin
         advance_s = 1'b0;
      end
   end

   // Play-state next-state logic; running off the end of the playlist overrides play_pause.
   always_comb begin
      state_nx_s = state_r;
      if (stop_s) begin
         state_nx_s = ST_STOPPED;
      end else begin
         case (state_r)
            ST_STOPPED: state_nx_s = edge_s[BTN_PLAY_PAUSE] ? ST_PLAYING : ST_STOPPED;
            ST_PLAYING: state_nx_s = edge_s[BTN_PLAY_PAUSE] ? ST_PAUSED  : ST_PLAYING;
            ST_PAUSED:  state_nx_s = edge_s[BTN_PLAY_PAUSE] ? ST_PLAYING : ST_PAUSED;
            default:    state_nx_s = ST_STOPPED;
         endcase
      end
   end

   // State, song index and registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_STOPPED;
         song_index_r <= '0;
         playing_r    <= 1'b0;
         song_start_r <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         song_index_r <= song_nx_s;
         playing_r    <= (state_nx_s == ST_PLAYING);
         song_start_r <= load_s;
      end
   end

   play_position_counter #(
      .SONG_ADDR_W     (SONG_ADDR_W),
      .SAMPLES_PER_SEC (SAMPLES_PER_SEC)
   ) u_position (
      .clk         (clk),
      .reset       (reset),
      .advance     (advance_s),
      .load_zero   (load_s),
      .seek_fwd    (seek_fwd_s),
      .seek_back   (seek_back_s),
      .step_s      (step_s),
      .sample_addr (sample_addr_s),
      .elapsed_s   (elapsed_s)
   );

   assign bus.rom_addr   = {song_index_r, sample_addr_s};
   assign bus.song_index = song_index_r;
   assign bus.playing    = playing_r;
   assign bus.elapsed_s  = elapsed_s;
   assign bus.song_start = song_start_r;
endmodule
